// File: rtl/slot_round_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slot_round_controller
// Purpose  : Runs one slot round: bet, charge, three-reel spin/stop, classify,
//            payout. Owns the player credit and progressive jackpot registers.
// Revision : 1.0 - initial release
// ============================================================================
module slot_round_controller #(
    parameter logic [16:0] INIT_CREDITS = 17'd500,
    parameter logic [16:0] JACKPOT_SEED = 17'd5000,
    parameter logic [16:0] COST_SINGLE  = 17'd10,
    parameter logic [16:0] COST_MAX     = 17'd50,
    parameter logic [16:0] PAY_SINGLE   = 17'd200,
    parameter logic [16:0] PAY_MAX      = 17'd1000,
    parameter int          AUTO_STOP    = 16
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        bet_max,
    input  logic        stop,
    output logic [11:0] reels,
    output logic [16:0] credits,
    output logic [16:0] jackpot,
    output logic        busy,
    output logic        win,
    output logic        jackpot_win,
    output logic        no_funds
);

    localparam int CNT_W = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(AUTO_STOP - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [16:0]      c_sat_max  = 17'h1FFFF;
    localparam logic [1:0]       c_cls_none    = 2'd0;
    localparam logic [1:0]       c_cls_match   = 2'd1;
    localparam logic [1:0]       c_cls_jackpot = 2'd2;
    localparam logic [3:0]       c_step0    = 4'd1;
    localparam logic [3:0]       c_step1    = 4'd3;
    localparam logic [3:0]       c_step2    = 4'd7;
    localparam logic [3:0]       c_seven    = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHARGE = 3'd1,
        S_SPIN0  = 3'd2,
        S_SPIN1  = 3'd3,
        S_SPIN2  = 3'd4,
        S_EVAL   = 3'd5,
        S_PAYOUT = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_reel0;
    logic [3:0]       r_reel1;
    logic [3:0]       r_reel2;
    logic [16:0]      r_credits;
    logic [16:0]      r_jackpot;
    logic [CNT_W-1:0] r_stop_cnt;
    logic             r_bet_max;
    logic [1:0]       r_class;
    logic             r_win;
    logic             r_jackpot_win;
    logic             r_no_funds;

    logic [16:0]      w_cost_req;
    logic [16:0]      w_cost_lat;
    logic             w_accept;
    logic             w_reject;
    logic             w_stop_edge;
    logic             w_adv0;
    logic             w_adv1;
    logic             w_adv2;
    logic             w_all_eq;

    function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [16:0] b);
        logic [17:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[17] ? c_sat_max : s[16:0];
    endfunction

    function automatic logic [3:0] bcd_step(input logic [3:0] v, input logic [3:0] inc);
        logic [4:0] s;
        s = {1'b0, v} + {1'b0, inc};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_cost_req  = bet_max   ? COST_MAX : COST_SINGLE;
        w_cost_lat  = r_bet_max ? COST_MAX : COST_SINGLE;
        w_accept    = (r_state == S_IDLE) && start && (r_credits >= w_cost_req);
        w_reject    = (r_state == S_IDLE) && start && (r_credits <  w_cost_req);
        // A player stop coinciding with the timeout is still a single stop.
        w_stop_edge = stop || (r_stop_cnt == c_cnt_last);
        // Reel k freezes on the stop edge of SPINk; later reels keep turning.
        w_adv0      = (r_state == S_SPIN0) && !w_stop_edge;
        w_adv1      = (r_state == S_SPIN0) || ((r_state == S_SPIN1) && !w_stop_edge);
        w_adv2      = (r_state == S_SPIN0) || (r_state == S_SPIN1) ||
                      ((r_state == S_SPIN2) && !w_stop_edge);
        w_all_eq    = (r_reel0 == r_reel1) && (r_reel1 == r_reel2);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)    w_state_nxt = S_CHARGE;
            S_CHARGE:                  w_state_nxt = S_SPIN0;
            S_SPIN0:  if (w_stop_edge) w_state_nxt = S_SPIN1;
            S_SPIN1:  if (w_stop_edge) w_state_nxt = S_SPIN2;
            S_SPIN2:  if (w_stop_edge) w_state_nxt = S_EVAL;
            S_EVAL:                    w_state_nxt = S_PAYOUT;
            S_PAYOUT:                  w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_reel0       <= 4'd0;
            r_reel1       <= 4'd0;
            r_reel2       <= 4'd0;
            r_credits     <= INIT_CREDITS;
            r_jackpot     <= JACKPOT_SEED;
            r_stop_cnt    <= c_cnt_zero;
            r_bet_max     <= 1'b0;
            r_class       <= c_cls_none;
            r_win         <= 1'b0;
            r_jackpot_win <= 1'b0;
            r_no_funds    <= 1'b0;
        end else begin
            r_win         <= 1'b0;
            r_jackpot_win <= 1'b0;
            r_no_funds    <= w_reject;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bet_max <= bet_max;
                    end
                end
                S_CHARGE: begin
                    r_credits  <= r_credits - w_cost_lat;
                    r_jackpot  <= sat_add(r_jackpot, w_cost_lat);
                    r_reel0    <= 4'd0;
                    r_reel1    <= 4'd0;
                    r_reel2    <= 4'd0;
                    r_stop_cnt <= c_cnt_zero;
                end
                S_SPIN0, S_SPIN1, S_SPIN2: begin
                    if (w_adv0) r_reel0 <= bcd_step(r_reel0, c_step0);
                    if (w_adv1) r_reel1 <= bcd_step(r_reel1, c_step1);
                    if (w_adv2) r_reel2 <= bcd_step(r_reel2, c_step2);
                    r_stop_cnt <= w_stop_edge ? c_cnt_zero : (r_stop_cnt + c_cnt_one);
                end
                S_EVAL: begin
                    if (w_all_eq && (r_reel0 == c_seven) && r_bet_max) begin
                        r_class <= c_cls_jackpot;
                    end else if (w_all_eq) begin
                        r_class <= c_cls_match;
                    end else begin
                        r_class <= c_cls_none;
                    end
                end
                S_PAYOUT: begin
                    if (r_class == c_cls_jackpot) begin
                        r_credits     <= sat_add(r_credits, r_jackpot);
                        r_jackpot     <= JACKPOT_SEED;
                        r_win         <= 1'b1;
                        r_jackpot_win <= 1'b1;
                    end else if (r_class == c_cls_match) begin
                        r_credits <= sat_add(r_credits, r_bet_max ? PAY_MAX : PAY_SINGLE);
                        r_win     <= 1'b1;
                    end
                end
                default: begin
                    r_class <= c_cls_none;
                end
            endcase
        end
    end

    assign reels       = {r_reel0, r_reel1, r_reel2};
    assign credits     = r_credits;
    assign jackpot     = r_jackpot;
    assign busy        = (r_state != S_IDLE);
    assign win         = r_win;
    assign jackpot_win = r_jackpot_win;
    assign no_funds    = r_no_funds;

endmodule
`default_nettype wire

// File: tb/tb_slot_round_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_slot_round_controller
// Purpose  : Scoreboard bench for slot_round_controller (three parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_round_controller;

    localparam int N = 3;
    localparam logic [16:0] INITS [N] = '{17'd500,  17'd40,   17'd131056};
    localparam logic [16:0] SEEDS [N] = '{17'd5000, 17'd5000, 17'd131066};

    localparam int K_RESET  = 0;
    localparam int K_ROUND  = 1;
    localparam int K_REJECT = 2;
    localparam int K_PROBE  = 3;

    typedef struct {
        int          kind;
        logic [11:0] reels;
        logic [16:0] credits;
        logic [16:0] jackpot;
        int          wins;
        int          jps;
        int          busy_cyc;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        resetn      [N];
    logic        start       [N];
    logic        bet_max     [N];
    logic        stop        [N];
    logic        probe       [N];
    logic [11:0] reels       [N];
    logic [16:0] credits     [N];
    logic [16:0] jackpot     [N];
    logic        busy        [N];
    logic        win         [N];
    logic        jackpot_win [N];
    logic        no_funds    [N];

    exp_t sb [N][$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, i, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [11:0] r, input logic [16:0] c,
                                input logic [16:0] j, input int w, input int jp, input int b);
        exp_t e;
        e.kind = k; e.reels = r; e.credits = c; e.jackpot = j;
        e.wins = w; e.jps = jp; e.busy_cyc = b;
        return e;
    endfunction

    task automatic take(input int i, input int kind, output exp_t e, output bit ok);
        e  = mk(-1, 12'h0, 17'd0, 17'd0, 0, 0, 0);
        ok = 1'b0;
        if (sb[i].size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_event dut%0d: got kind %0d expected no event", i, kind);
        end else begin
            e = sb[i].pop_front();
            chk("event_kind", i, kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        slot_round_controller #(
            .INIT_CREDITS(INITS[g]),
            .JACKPOT_SEED(SEEDS[g])
        ) u_dut (
            .CLOCK_50   (CLOCK_50),
            .resetn     (resetn[g]),
            .start      (start[g]),
            .bet_max    (bet_max[g]),
            .stop       (stop[g]),
            .reels      (reels[g]),
            .credits    (credits[g]),
            .jackpot    (jackpot[g]),
            .busy       (busy[g]),
            .win        (win[g]),
            .jackpot_win(jackpot_win[g]),
            .no_funds   (no_funds[g])
        );

        int   bcnt      = 0;
        int   wcnt      = 0;
        int   jcnt      = 0;
        logic rst_prev  = 1'b1;
        logic busy_prev = 1'b0;

        always @(negedge CLOCK_50) begin
            exp_t e;
            bit   ok;
            if (!resetn[g]) begin
                if (rst_prev) begin
                    take(g, K_RESET, e, ok);
                    if (ok) begin
                        chk("rst_reels",   g, reels[g],       e.reels);
                        chk("rst_credits", g, credits[g],     e.credits);
                        chk("rst_jackpot", g, jackpot[g],     e.jackpot);
                        chk("rst_busy",    g, busy[g],        0);
                        chk("rst_pulses",  g, {win[g], jackpot_win[g], no_funds[g]}, 0);
                    end
                end
                bcnt = 0; wcnt = 0; jcnt = 0;
            end else begin
                if (busy[g])        bcnt++;
                if (win[g])         wcnt++;
                if (jackpot_win[g]) jcnt++;
                if (no_funds[g]) begin
                    take(g, K_REJECT, e, ok);
                    if (ok) begin
                        chk("rej_credits", g, credits[g], e.credits);
                        chk("rej_busy",    g, busy[g],    0);
                    end
                end
                if (!busy[g] && busy_prev) begin
                    take(g, K_ROUND, e, ok);
                    if (ok) begin
                        chk("round_reels",   g, reels[g],   e.reels);
                        chk("round_credits", g, credits[g], e.credits);
                        chk("round_jackpot", g, jackpot[g], e.jackpot);
                        chk("round_win",     g, wcnt,       e.wins);
                        chk("round_jp_win",  g, jcnt,       e.jps);
                        chk("round_busy",    g, bcnt,       e.busy_cyc);
                    end
                    bcnt = 0; wcnt = 0; jcnt = 0;
                end
                if (probe[g]) begin
                    take(g, K_PROBE, e, ok);
                    if (ok) begin
                        chk("hold_reels",   g, reels[g],   e.reels);
                        chk("hold_credits", g, credits[g], e.credits);
                        chk("hold_jackpot", g, jackpot[g], e.jackpot);
                        chk("hold_busy",    g, busy[g],    0);
                    end
                end
            end
            rst_prev  = resetn[g];
            busy_prev = busy[g];
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic stage(input int i, input int lows);
        repeat (lows) begin
            stop[i] = 1'b0;
            tick();
        end
        stop[i] = 1'b1;
        tick();
        stop[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int k;
        k = 0;
        while (busy[i] && k < 200) begin
            tick();
            k++;
        end
        if (busy[i]) begin
            n_vec++;
            n_miss++;
            $display("FAIL round_timeout dut%0d: got busy after %0d cycles expected idle", i, k);
        end
        tick();
    endtask

    task automatic launch(input int i, input bit bm);
        tick();
        start[i]   = 1'b1;
        bet_max[i] = bm;
        tick();
        start[i]   = 1'b0;
        tick();
    endtask

    // l0 < 0 means stop stays low for the whole round.
    task automatic run_round(input int i, input bit bm, input int l0, input int l1, input int l2,
                             input logic [11:0] er, input logic [16:0] ec, input logic [16:0] ej,
                             input int ew, input int ejp, input int eb);
        sb[i].push_back(mk(K_ROUND, er, ec, ej, ew, ejp, eb));
        launch(i, bm);
        if (l0 >= 0) begin
            stage(i, l0);
            stage(i, l1);
            stage(i, l2);
        end
        wait_idle(i);
    endtask

    task automatic reject(input int i, input bit bm, input logic [16:0] ec);
        tick();
        sb[i].push_back(mk(K_REJECT, 12'h0, ec, 17'd0, 0, 0, 0));
        start[i]   = 1'b1;
        bet_max[i] = bm;
        tick();
        start[i]   = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            resetn[i] = 1'b0; start[i] = 1'b0; bet_max[i] = 1'b0;
            stop[i]   = 1'b0; probe[i] = 1'b0;
            sb[i].push_back(mk(K_RESET, 12'h0, INITS[i], SEEDS[i], 0, 0, 0));
        end
        repeat (3) tick();
        for (int i = 0; i < N; i++) resetn[i] = 1'b1;
        repeat (3) tick();
        sb[0].push_back(mk(K_PROBE, 12'h000, 17'd500, 17'd5000, 0, 0, 0));
        probe[0] = 1'b1;
        tick();
        probe[0] = 1'b0;

        run_round(0, 1'b1, 5, 9, 9, 12'h555, 17'd1450, 17'd5050, 1, 0, 29);
        run_round(0, 1'b1, 7, 1, 1, 12'h777, 17'd6500, 17'd5000, 1, 1, 15);
        run_round(0, 1'b0, 7, 1, 1, 12'h777, 17'd6690, 17'd5010, 1, 0, 15);
        run_round(0, 1'b0, -1, 0, 0, 12'h539, 17'd6680, 17'd5020, 0, 0, 51);

        // Abort mid-SPIN1: reset lands between clock edges.
        launch(0, 1'b1);
        stage(0, 2);
        tick();
        tick();
        #2;
        sb[0].push_back(mk(K_RESET, 12'h0, 17'd500, 17'd5000, 0, 0, 0));
        resetn[0] = 1'b0;
        tick();
        resetn[0] = 1'b1;
        tick();
        run_round(0, 1'b1, -1, 0, 0, 12'h539, 17'd450, 17'd5050, 0, 0, 51);
        run_round(0, 1'b0, 15, 15, 15, 12'h539, 17'd440, 17'd5060, 0, 0, 51);
        run_round(0, 1'b0, 0, 0, 0, 12'h034, 17'd430, 17'd5070, 0, 0, 6);

        reject(1, 1'b1, 17'd40);
        run_round(1, 1'b0, -1, 0, 0, 12'h539, 17'd30, 17'd5010, 0, 0, 51);
        reject(1, 1'b1, 17'd30);

        run_round(2, 1'b0, 7, 1, 1, 12'h777, 17'h1FFFF, 17'h1FFFF, 1, 0, 15);
        run_round(2, 1'b1, 7, 1, 1, 12'h777, 17'h1FFFF, 17'd131066, 1, 1, 15);

        repeat (3) tick();
        for (int i = 0; i < N; i++) chk("sb_drain", i, sb[i].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slot_round_controller.md
Name: slot_round_controller

Overview:
- Sequences one slot-machine round end to end: accepts a bet, charges credits, spins and stops three BCD reels, classifies the result, and pays out.
- Owns the player credit register and the progressive jackpot pool register.
- Produces the 12-bit reel word in the same {reel0, reel1, reel2} nibble layout that the spin checker consumes.
- Sits between the board inputs (KEY/SW) and the display and score logic.

Parameters:
- INIT_CREDITS, 500: credits after reset.
- JACKPOT_SEED, 5000: jackpot pool after reset and after each jackpot payout.
- COST_SINGLE, 10: credits charged for a single bet.
- COST_MAX, 50: credits charged for a max bet.
- PAY_SINGLE, 200: payout for three matching digits on a single bet.
- PAY_MAX, 1000: payout for three matching digits on a max bet.
- AUTO_STOP, 16: maximum cycles spent in one spin state before a forced stop.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a round; sampled only in IDLE.
- bet_max  in  1  1 = max bet, 0 = single bet; sampled with start.
- stop  in  1  player stop request for the current reel; level-sampled each cycle.
- reels  out  12  [11:8]=reel0, [7:4]=reel1, [3:0]=reel2, each BCD 0-9.
- credits  out  17  player credits.
- jackpot  out  17  jackpot pool.
- busy  out  1  high in every state except IDLE.
- win  out  1  one-cycle pulse on a three-match payout (includes jackpot).
- jackpot_win  out  1  one-cycle pulse on a jackpot payout.
- no_funds  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async, resetn=0), values of all outputs:
  - credits=INIT_CREDITS, jackpot=JACKPOT_SEED, reels=0.
  - busy, win, jackpot_win, no_funds = 0.
  - state=IDLE, stop counter=0.
  - Reset asserted mid-round aborts the round with no refund and no payout.
- Cost is selected by bet_max: cost = COST_MAX if bet_max=1, else COST_SINGLE.
- IDLE:
  - start=1 and credits >= cost: latch bet_max and go to CHARGE.
  - start=1 and credits < cost: pulse no_funds for 1 cycle and stay in IDLE.
  - start and stop are ignored in every state other than the one where they are sampled.
- CHARGE (1 cycle):
  - credits -= cost.
  - jackpot += cost, saturating at 17'h1FFFF.
  - reels cleared to 0.
  - Go to SPIN0.
- SPINk, k = 0, 1, 2:
  - On every edge, each unfrozen reel advances mod 10: reel0 +1, reel1 +3, reel2 +7.
  - The stop edge is an edge with stop=1, or the AUTO_STOP-th edge in the state.
  - On the stop edge, reel k is frozen at its current value (it does not advance); higher reels still advance.
  - On the stop edge the controller moves to SPIN(k+1), or to EVAL after SPIN2.
  - The stop counter clears on entry to each SPIN state.
  - If stop=1 and the timeout occur on the same edge, this is one stop, not two.
- EVAL (1 cycle): classify the frozen reels as
  - JACKPOT: all three reels = 7 and latched bet_max = 1.
  - MATCH: all three reels equal, otherwise (this includes 777 on a single bet).
  - NONE: any other result.
- PAYOUT (1 cycle), then IDLE:
  - MATCH: credits += PAY_MAX if latched bet_max=1, else PAY_SINGLE; pulse win.
  - JACKPOT: credits += jackpot; jackpot <= JACKPOT_SEED; pulse win and jackpot_win.
  - All credit additions saturate at 17'h1FFFF.
- reels hold their final values in IDLE until the next CHARGE.
- Round latency with no player stops: 1 + 3·AUTO_STOP + 2 cycles of busy (51 at the defaults).

Test Plan:
1. Reset -> credits=500, jackpot=5000, reels=12'h000, busy=0. Release reset -> all values hold.
2. start with bet_max=1; stop pattern per spin state = (low 5 cycles, high 1), (low 9, high 1), (low 9, high 1) -> reels=12'h555, win pulse, credits=500-50+1000=1450, jackpot=5050.
3. start with bet_max=1; stop pattern = (low 7, high 1), (low 1, high 1), (low 1, high 1) -> reels=12'h777, win and jackpot_win pulse, credits=450+5050=5500, jackpot=5000. Repeat the same pattern with bet_max=0 -> win only, credits +200.
4. start with bet_max=0 and stop held low -> reels=12'h539, busy high exactly 51 cycles, credits=490, jackpot=5010, no pulses.
5. INIT_CREDITS=40: start with bet_max=1 -> no_funds pulse, credits stays 40, busy stays 0. Then start with bet_max=0 -> accepted, credits=30.
6. Assert resetn=0 during SPIN1 -> immediate reset values. After release, a new round completes normally.
7. Saturation: preload credits near 17'h1FFFF and win a MATCH payout -> credits = 17'h1FFFF.
